// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the 32-bit combinational ALU.
// It accepts one R-type request at a time, drives registered operands and
// a decoded control code into the ALU, captures the ALU outputs one cycle
// later, and holds them on a response channel until they are consumed.
// It also keeps a saturating count of legal operations that overflowed.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [3:0]       r_ctrl;
  logic             r_illegal;
  logic [31:0]      r_rspResult;
  logic [3:0]       r_rspFlags;
  logic [CNT_W-1:0] r_ovfCount;
  logic [3:0]       w_decCtrl;
  logic             w_decIllegal;
  logic             w_accept;
  logic             w_capture;

  // A new request may enter when idle, or when the held response is being
  // consumed this very cycle; this makes back-to-back issue possible.
  assign req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign rsp_valid = (r_state == RESP);
  assign w_accept  = req_valid && req_ready;
  assign w_capture = (r_state == EXEC);

  assign alu_src1   = r_src1;
  assign alu_src2   = r_src2;
  assign alu_ctrl   = r_ctrl;
  assign rsp_result = r_rspResult;
  assign rsp_flags  = r_rspFlags;
  assign ovf_count  = r_ovfCount;

  // Decode the R-type funct field into the ALU control code; unknown codes
  // run the ALU as AND and are marked illegal so the response can be forced.
  always_comb begin
    w_decCtrl    = 4'b0000;
    w_decIllegal = 1'b0;
    case (req_funct)
      6'h24:   w_decCtrl = 4'b0000;
      6'h25:   w_decCtrl = 4'b0001;
      6'h20:   w_decCtrl = 4'b0010;
      6'h22:   w_decCtrl = 4'b0110;
      6'h27:   w_decCtrl = 4'b1100;
      6'h26:   w_decCtrl = 4'b1101;
      6'h2A:   w_decCtrl = 4'b0111;
      default: w_decIllegal = 1'b1;
    endcase
  end

  // State register for the IDLE -> EXEC -> RESP sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: EXEC always lasts exactly one cycle, RESP waits for
  // the consumer and may chain straight into the next EXEC.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_nextState = EXEC;
      end
      EXEC: begin
        w_nextState = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (req_valid) w_nextState = EXEC;
          else           w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand and control registers only move on an accept edge, so the ALU
  // inputs stay frozen through EXEC and any length of response stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1    <= 32'd0;
      r_src2    <= 32'd0;
      r_ctrl    <= 4'b0000;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_src1    <= req_src1;
      r_src2    <= req_src2;
      r_ctrl    <= w_decCtrl;
      r_illegal <= w_decIllegal;
    end
  end

  // Capture the ALU outputs at the end of EXEC; illegal ops return a fixed
  // zero result with the illegal and zero flags, ignoring the ALU entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspResult <= 32'd0;
      r_rspFlags  <= 4'b0000;
    end else if (w_capture) begin
      if (r_illegal) begin
        r_rspResult <= 32'd0;
        r_rspFlags  <= 4'b1001;
      end else begin
        r_rspResult <= alu_result;
        r_rspFlags  <= {1'b0, alu_overflow, alu_cout, alu_zero};
      end
    end
  end

  // Saturating overflow-event counter; a clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovfCount <= '0;
    end else if (ovf_clr) begin
      r_ovfCount <= '0;
    end else if (w_capture && !r_illegal && alu_overflow && (r_ovfCount != CNT_MAX)) begin
      r_ovfCount <= r_ovfCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a small
// behavioural ALU closing the loop between alu_src*/alu_ctrl and alu_*.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        ovf_clr;
  logic [1:0]  ovf_count;

  logic        forceOvf;
  int          passCount;
  int          checkCount;

  alu_issue_ctrl #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct    (req_funct),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .ovf_clr      (ovf_clr),
    .ovf_count    (ovf_count)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry and overflow only come from ADD/SUB; forceOvf
  // lets a test assert overflow regardless of the operation.
  always_comb begin
    logic [32:0] sum;
    sum          = 33'd0;
    alu_result   = 32'd0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b0010: begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'b0110: begin
        sum          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      4'b1101: alu_result = ~(alu_src1 & alu_src2);
      4'b0111: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_overflow = alu_overflow | forceOvf;
  end

  // Drive one request from IDLE through EXEC into RESP, optionally pulsing
  // ovf_clr during EXEC; returns what was seen on the ALU side during EXEC.
  task automatic sendOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, output logic [3:0] ctrlSeen, output logic validSeen);
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = f;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ovf_clr   = clr;
    ctrlSeen  = alu_ctrl;
    validSeen = rsp_valid;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  // Consume the held response and return to IDLE.
  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checkCount++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_ctrl !== 4'b0000 || ovf_count !== 2'd0 ||
        rsp_result !== 32'd0 || rsp_flags !== 4'b0000 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0)
      $display("[TB] FAIL reset_values: valid=%b ready=%b ctrl=%b cnt=%0d res=%h flags=%b src1=%h src2=%h, expected 0 1 0000 0 0 0000 0 0",
               rsp_valid, req_ready, alu_ctrl, ovf_count, rsp_result, rsp_flags, alu_src1, alu_src2);
    else passCount++;
  endtask

  task automatic test_add();
    logic [3:0] ctrlSeen;
    logic       validSeen;
    sendOp(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ctrlSeen, validSeen);
    checkCount++;
    if (ctrlSeen !== 4'b0010 || validSeen !== 1'b0)
      $display("[TB] FAIL add_exec: ctrl=%b valid=%b, expected 0010 0", ctrlSeen, validSeen);
    else passCount++;
    checkCount++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h8000_0000 || rsp_flags !== 4'b0100 || ovf_count !== 2'd1)
      $display("[TB] FAIL add_resp: valid=%b res=%h flags=%b cnt=%0d, expected 1 80000000 0100 1",
               rsp_valid, rsp_result, rsp_flags, ovf_count);
    else passCount++;
    consume();
    checkCount++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL add_consumed: valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
    else passCount++;
  endtask

  task automatic test_illegal();
    logic [3:0] ctrlSeen;
    logic       validSeen;
    forceOvf = 1'b1;
    sendOp(6'h3F, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ctrlSeen, validSeen);
    forceOvf = 1'b0;
    checkCount++;
    if (ctrlSeen !== 4'b0000)
      $display("[TB] FAIL illegal_ctrl: ctrl=%b, expected 0000", ctrlSeen);
    else passCount++;
    checkCount++;
    if (rsp_result !== 32'd0 || rsp_flags !== 4'b1001 || ovf_count !== 2'd1)
      $display("[TB] FAIL illegal_resp: res=%h flags=%b cnt=%0d, expected 0 1001 1",
               rsp_result, rsp_flags, ovf_count);
    else passCount++;
    consume();
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = 6'h20;
    req_src1  = 32'h7FFF_FFFF;
    req_src2  = 32'h0000_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_ctrl !== 4'b0000 || ovf_count !== 2'd0 || alu_src1 !== 32'd0)
      $display("[TB] FAIL reset_mid_exec: valid=%b ready=%b ctrl=%b cnt=%0d src1=%h, expected 0 1 0000 0 0",
               rsp_valid, req_ready, alu_ctrl, ovf_count, alu_src1);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int staleCycles;
      staleCycles = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        if (rsp_valid !== 1'b0 || ovf_count !== 2'd0) staleCycles++;
      end
      checkCount++;
      if (staleCycles != 0)
        $display("[TB] FAIL reset_no_stale: stale cycles=%0d, expected 0", staleCycles);
      else passCount++;
    end
  endtask

  task automatic test_sub_slt();
    logic [3:0] ctrlSeen;
    logic       validSeen;
    sendOp(6'h22, 32'd5, 32'd5, 1'b0, ctrlSeen, validSeen);
    checkCount++;
    if (ctrlSeen !== 4'b0110 || rsp_result !== 32'd0 || rsp_flags !== 4'b0011)
      $display("[TB] FAIL sub_equal: ctrl=%b res=%h flags=%b, expected 0110 0 0011", ctrlSeen, rsp_result, rsp_flags);
    else passCount++;
    consume();
    sendOp(6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, ctrlSeen, validSeen);
    checkCount++;
    if (ctrlSeen !== 4'b0111 || rsp_result !== 32'd1 || rsp_flags !== 4'b0000)
      $display("[TB] FAIL slt_neg: ctrl=%b res=%h flags=%b, expected 0111 1 0000", ctrlSeen, rsp_result, rsp_flags);
    else passCount++;
    consume();
  endtask

  task automatic test_decode();
    logic [5:0]  functs [4] = '{6'h24, 6'h25, 6'h27, 6'h26};
    logic [3:0]  ctrls  [4] = '{4'b0000, 4'b0001, 4'b1100, 4'b1101};
    logic [31:0] results[4] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'h000F_0000, 32'hFF0F_EDCB};
    logic [3:0]  ctrlSeen;
    logic        validSeen;
    for (int i = 0; i < 4; i++) begin
      sendOp(functs[i], 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, ctrlSeen, validSeen);
      checkCount++;
      if (ctrlSeen !== ctrls[i] || rsp_result !== results[i] || rsp_flags !== 4'b0000)
        $display("[TB] FAIL decode_%0d: ctrl=%b res=%h flags=%b, expected %b %h 0000",
                 i, ctrlSeen, rsp_result, rsp_flags, ctrls[i], results[i]);
      else passCount++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ctrlSeen;
    logic       validSeen;
    int         unstable;
    sendOp(6'h20, 32'd3, 32'd4, 1'b0, ctrlSeen, validSeen);
    unstable = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 32'd7 ||
          rsp_flags !== 4'b0000 || alu_src1 !== 32'd3 || alu_ctrl !== 4'b0010) unstable++;
    end
    checkCount++;
    if (unstable != 0)
      $display("[TB] FAIL stall_stable: bad cycles=%0d, expected 0", unstable);
    else passCount++;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_funct = 6'h22;
    req_src1  = 32'd10;
    req_src2  = 32'd3;
    #1;
    checkCount++;
    if (req_ready !== 1'b1)
      $display("[TB] FAIL b2b_ready: ready=%b, expected 1", req_ready);
    else passCount++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checkCount++;
    if (rsp_valid !== 1'b0 || alu_ctrl !== 4'b0110 || alu_src1 !== 32'd10)
      $display("[TB] FAIL b2b_exec: valid=%b ctrl=%b src1=%h, expected 0 0110 a", rsp_valid, alu_ctrl, alu_src1);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_flags !== 4'b0010)
      $display("[TB] FAIL b2b_resp: valid=%b res=%h flags=%b, expected 1 7 0010", rsp_valid, rsp_result, rsp_flags);
    else passCount++;
    consume();
  endtask

  task automatic test_saturation();
    logic [1:0] expCnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [3:0] ctrlSeen;
    logic       validSeen;
    for (int i = 0; i < 4; i++) begin
      sendOp(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ctrlSeen, validSeen);
      checkCount++;
      if (ovf_count !== expCnt[i])
        $display("[TB] FAIL saturate_%0d: count=%0d, expected %0d", i, ovf_count, expCnt[i]);
      else passCount++;
      consume();
    end
    sendOp(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, ctrlSeen, validSeen);
    checkCount++;
    if (ovf_count !== 2'd0 || rsp_flags !== 4'b0100)
      $display("[TB] FAIL clear_priority: count=%0d flags=%b, expected 0 0100", ovf_count, rsp_flags);
    else passCount++;
    consume();
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Sequence all scenarios and print the summary.
  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct  = 6'h00;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    rsp_ready  = 1'b0;
    ovf_clr    = 1'b0;
    forceOvf   = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add();
    test_illegal();
    test_reset_mid_exec();
    test_sub_slt();
    test_decode();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
